// File: rtl/vdp_super_palette_pkg.sv
// rtl/vdp_super_palette_pkg.sv - shared types and default table for the super-res palette
package vdp_super_palette_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pal_rgb_t;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } pal_state_t;

    // MSX2 power-on palette, 3-bit channels widened as {v, v[2]}
    localparam pal_rgb_t SUPER_PAL_DEFAULT [16] = '{
        12'h000, 12'h000, 12'h2D2, 12'h6F6,
        12'h22F, 12'h46F, 12'hB22, 12'h4DF,
        12'hF22, 12'hF66, 12'hDD2, 12'hDD9,
        12'h292, 12'hD4B, 12'hBBB, 12'hFFF
    };

endpackage

// File: rtl/vdp_super_palette_ram.sv
// rtl/vdp_super_palette_ram.sv - palette storage, one write port, one registered read-before-write port
module vdp_super_palette_ram
    import vdp_super_palette_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we,
    input  logic [3:0] waddr,
    input  pal_rgb_t   wdata,
    input  logic [3:0] raddr,
    input  logic       rd_clear,
    output pal_rgb_t   rdata
);

    pal_rgb_t mem [DEPTH];

    // Reset clears the array so a table without INIT reads back as 0x000
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rdata <= rd_clear ? pal_rgb_t'('0) : mem[raddr];
        end
    end

endmodule

// File: rtl/vdp_super_palette.sv
// rtl/vdp_super_palette.sv - 16-entry 4:4:4 super-res palette with default-table loader and CPU write sequencer
module vdp_super_palette
    import vdp_super_palette_pkg::*;
#(
    parameter int ENTRIES       = 16,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pal_index_wr,
    input  logic [3:0] pal_index_data,
    input  logic       pal_data_wr,
    input  logic [7:0] pal_data,
    input  logic [3:0] PALETTE_ADDR2,
    output logic [3:0] PALETTE_DATA_R2_OUT,
    output logic [3:0] PALETTE_DATA_G2_OUT,
    output logic [3:0] PALETTE_DATA_B2_OUT,
    output logic       init_busy
);

    localparam logic [3:0] LAST_ENTRY = 4'(ENTRIES - 1);

    pal_state_t state, state_nx;
    logic [3:0] init_cnt;
    logic [3:0] wr_idx;
    logic       phase;
    logic [7:0] rb_byte;

    logic       ram_we;
    logic [3:0] ram_waddr;
    pal_rgb_t   ram_wdata;
    pal_rgb_t   ram_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT_ON_RESET ? INIT : IDLE;
            init_cnt <= '0;
            wr_idx   <= '0;
            phase    <= 1'b0;
            rb_byte  <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) begin
                init_cnt <= init_cnt + 4'd1;
            end else if (pal_index_wr) begin
                // Index write wins over a coincident data byte and drops any half-written entry
                wr_idx <= pal_index_data;
                phase  <= 1'b0;
            end else if (pal_data_wr) begin
                if (!phase) begin
                    rb_byte <= pal_data;
                    phase   <= 1'b1;
                end else begin
                    phase  <= 1'b0;
                    wr_idx <= wr_idx + 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_nx  = state;
        ram_we    = 1'b0;
        ram_waddr = wr_idx;
        ram_wdata = '{r: rb_byte[7:4], g: pal_data[3:0], b: rb_byte[3:0]};
        case (state)
            INIT: begin
                ram_we    = 1'b1;
                ram_waddr = init_cnt;
                ram_wdata = SUPER_PAL_DEFAULT[init_cnt];
                if (init_cnt == LAST_ENTRY) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                ram_we = pal_data_wr && !pal_index_wr && phase;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    vdp_super_palette_ram #(
        .DEPTH(ENTRIES)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr   (PALETTE_ADDR2),
        .rd_clear(state == INIT),
        .rdata   (ram_rdata)
    );

    assign PALETTE_DATA_R2_OUT = ram_rdata.r;
    assign PALETTE_DATA_G2_OUT = ram_rdata.g;
    assign PALETTE_DATA_B2_OUT = ram_rdata.b;
    assign init_busy           = (state == INIT);

endmodule
